// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// Buffered write-back initiator for the 32x64 register file. Results arrive
// through a valid/ready handshake. They are held in an in-order circular
// queue and drained onto the register file write port at one write per cycle.
// Two forwarding ports let readers see values that are queued but not yet
// written. Writes to register 31 (XZR) complete the handshake but are dropped.
//
// Ports
//   clk            sole clock; all state updates on the rising edge
//   reset          synchronous, active-low
//   in_valid       producer offers {in_reg, in_data}
//   in_ready       queue can accept (== !full)
//   in_reg         destination register number
//   in_data        result value
//   wb_hold        suppresses draining this cycle
//   RegWrite       register file write enable
//   WriteRegister  register file write address (0 when empty)
//   WriteData      register file write data (0 when empty)
//   fwd_reg1/2     read addresses checked against the queue
//   fwd_hit1/2     queue holds a pending write to that register
//   fwd_data1/2    youngest pending value for that register, 0 when no hit
//   count          current occupancy
//   empty, full    count == 0 / count == DEPTH
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state. It is low whenever the queue is
// full, even if a drain is taking place in the same cycle. The producer must
// hold in_reg/in_data stable while in_valid is high and in_ready is low.

module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_reg,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       wb_hold,
    output logic                       RegWrite,
    output logic [4:0]                 WriteRegister,
    output logic [WIDTH-1:0]           WriteData,
    input  logic [4:0]                 fwd_reg1,
    input  logic [4:0]                 fwd_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [WIDTH-1:0]           fwd_data1,
    output logic [WIDTH-1:0]           fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]       reg_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic accept, store, drain;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign in_ready = !full;
    assign RegWrite = !empty && !wb_hold;

    assign WriteRegister = empty ? 5'd0 : reg_q[head_q];
    assign WriteData     = empty ? '0   : data_q[head_q];

    assign accept = in_valid && in_ready;
    // An XZR result is accepted but never occupies an entry.
    assign store  = accept && (in_reg != XZR);
    assign drain  = RegWrite;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) head_d = head_q + PW'(1);
        if (store) tail_d = tail_q + PW'(1);
        if (store && !drain)      count_d = count_q + CW'(1);
        else if (!store && drain) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (store) begin
                reg_q[tail_q]  <= in_reg;
                data_q[tail_q] <= in_data;
            end
        end
    end

    // The scan walks from oldest to youngest, so a later match overrides an
    // earlier one and the youngest value wins. Entry contents outside the
    // occupied window are stale and masked by the occupancy test.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (fwd_reg1 != XZR && reg_q[idx] == fwd_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if (fwd_reg2 != XZR && reg_q[idx] == fwd_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Testbench for regfile_writeback_queue: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.

module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 64;
    localparam int CW    = $clog2(DEPTH+1);

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_reg;
    logic [WIDTH-1:0] in_data;
    logic             wb_hold;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       fwd_reg1, fwd_reg2;
    logic             fwd_hit1, fwd_hit2;
    logic [WIDTH-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0]    count;
    logic             empty, full;

    regfile_writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data),
        .wb_hold(wb_hold),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    // scoreboard: pending writes in acceptance order, {reg, data}
    logic [WIDTH+4:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver: apply inputs away from the rising edge, then let them settle
    task automatic drive(input logic v, input logic [4:0] r, input logic [63:0] d,
                         input logic h, input logic [4:0] f1, input logic [4:0] f2,
                         input logic rst_n);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        wb_hold  = h;
        fwd_reg1 = f1;
        fwd_reg2 = f2;
        reset    = rst_n;
        #1;
    endtask

    task automatic fwd_model(input logic [4:0] f, output logic hit, output logic [63:0] val);
        hit = 1'b0;
        val = '0;
        if (f != 5'd31) begin
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k][WIDTH+4:WIDTH] == f) begin
                    hit = 1'b1;
                    val = exp_q[k][WIDTH-1:0];
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        int            n;
        logic          h1, h2;
        logic [63:0]   v1, v2;
        n = exp_q.size();
        check_val("count",    64'(count),    64'(n));
        check_val("empty",    64'(empty),    64'(n == 0));
        check_val("full",     64'(full),     64'(n == DEPTH));
        check_val("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check_val("RegWrite", 64'(RegWrite), 64'((n > 0) && !wb_hold));
        check_val("WriteRegister", 64'(WriteRegister), (n > 0) ? 64'(exp_q[0][WIDTH+4:WIDTH]) : 64'd0);
        check_val("WriteData",     WriteData,          (n > 0) ? exp_q[0][WIDTH-1:0] : 64'd0);
        fwd_model(fwd_reg1, h1, v1);
        fwd_model(fwd_reg2, h2, v2);
        check_val("fwd_hit1",  64'(fwd_hit1), 64'(h1));
        check_val("fwd_data1", fwd_data1,     v1);
        check_val("fwd_hit2",  64'(fwd_hit2), 64'(h2));
        check_val("fwd_data2", fwd_data2,     v2);
    endtask

    // advance one clock and update the reference model with what was driven
    task automatic tick();
        logic do_acc, do_drain;
        do_acc   = in_valid && (exp_q.size() < DEPTH);
        do_drain = (exp_q.size() > 0) && !wb_hold;
        @(posedge clk);
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (do_drain) void'(exp_q.pop_front());
            if (do_acc && in_reg != 5'd31) exp_q.push_back({in_reg, in_data});
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [4:0] r, input logic [63:0] d,
                        input logic h, input logic [4:0] f1, input logic [4:0] f2);
        drive(v, r, d, h, f1, f2, 1'b1);
        check_model();
        tick();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);

        // reset then single write
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1'b1);
        check_model();
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        check_val("rst_regwrite", 64'(RegWrite), 64'd0);
        tick();
        step(1, 5, 64'hDEAD_BEEF, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 0, 1'b1);
        check_model();
        check_val("single_rw", 64'(RegWrite), 64'd1);
        check_val("single_wr", 64'(WriteRegister), 64'd5);
        check_val("single_wd", WriteData, 64'hDEAD_BEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1'b1);
        check_model();
        check_val("single_after_empty", 64'(empty), 64'd1);
        check_val("single_after_rw", 64'(RegWrite), 64'd0);
        tick();

        // fill under hold, then drain in order
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 64'(i * 16), 1, 5'(i), 0);
        drive(1, 5, 64'h50, 1, 0, 0, 1'b1);
        check_model();
        check_val("fill_count", 64'(count), 64'd4);
        check_val("fill_full", 64'(full), 64'd1);
        check_val("fill_ready", 64'(in_ready), 64'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1'b1);
            check_model();
            check_val("drain_rw", 64'(RegWrite), 64'd1);
            check_val("drain_wr", 64'(WriteRegister), 64'(i));
            check_val("drain_wd", WriteData, 64'(i * 16));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1'b1);
        check_val("drain_done", 64'(count), 64'd0);
        tick();

        // forwarding returns youngest
        step(1, 7, 64'hAA, 1, 0, 0);
        step(1, 7, 64'hBB, 1, 0, 0);
        drive(0, 0, 0, 1, 7, 8, 1'b1);
        check_model();
        check_val("fwd_young_hit", 64'(fwd_hit1), 64'd1);
        check_val("fwd_young_data", fwd_data1, 64'hBB);
        check_val("fwd_miss_hit", 64'(fwd_hit2), 64'd0);
        check_val("fwd_miss_data", fwd_data2, 64'd0);
        tick();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 7, 8);

        // XZR discard
        drive(1, 31, 64'hFFFF, 0, 31, 0, 1'b1);
        check_model();
        check_val("xzr_ready", 64'(in_ready), 64'd1);
        tick();
        drive(0, 0, 0, 0, 31, 31, 1'b1);
        check_model();
        check_val("xzr_count", 64'(count), 64'd0);
        check_val("xzr_rw", 64'(RegWrite), 64'd0);
        check_val("xzr_hit", 64'(fwd_hit1), 64'd0);
        tick();

        // back-to-back stream with wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(i), 64'(i * 3), 0, 5'(i), 0, 1'b1);
            check_model();
            check_val("stream_count", 64'(count <= 1), 64'd1);
            if (i > 0) begin
                check_val("stream_wr", 64'(WriteRegister), 64'(i - 1));
                check_val("stream_wd", WriteData, 64'((i - 1) * 3));
            end
            tick();
        end
        step(0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 9, 0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) step(1, 5'(20 + i), 64'(100 + i), 1, 0, 0);
        drive(0, 0, 0, 1, 20, 21, 1'b0);
        tick();
        drive(0, 0, 0, 1, 20, 21, 1'b1);
        check_model();
        check_val("mid_rst_count", 64'(count), 64'd0);
        check_val("mid_rst_rw", 64'(RegWrite), 64'd0);
        check_val("mid_rst_hit1", 64'(fwd_hit1), 64'd0);
        check_val("mid_rst_hit2", 64'(fwd_hit2), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 20, 22, 1'b1);
            check_model();
            check_val("mid_rst_nowrite", 64'(RegWrite), 64'd0);
            tick();
        end

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  r, f1, f2;
            logic [63:0] d;
            logic        v, h, rn;
            v  = ($urandom_range(0, 99) < 70);
            r  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
            d  = {$urandom, $urandom};
            h  = ($urandom_range(0, 99) < 35);
            f1 = 5'($urandom_range(26, 31));
            f2 = 5'($urandom_range(0, 31));
            rn = ($urandom_range(0, 199) != 0);
            drive(v, r, d, h, f1, f2, rn);
            check_model();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Buffered write-back initiator for the 32×64 register file. Accepts (register, data) results from the execute/memory stages through a valid/ready handshake, holds up to DEPTH in an in-order queue, and drains them onto the register file write port (RegWrite / WriteRegister / WriteData) at one write per cycle. Two forwarding ports let the register file's readers observe queued-but-unwritten values. Writes to register 31 (XZR) are discarded.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- WIDTH, 64, data width; matches register file WriteData
- clk  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- in_valid  input  1  producer offers a result
- in_ready  output  1  queue can accept; equals !full
- in_reg  input  5  destination register number
- in_data  input  WIDTH  result value
- wb_hold  input  1  suppresses draining this cycle
- RegWrite  output  1  register file write enable
- WriteRegister  output  5  register file write address
- WriteData  output  WIDTH  register file write data
- fwd_reg1, fwd_reg2  input  5 each  read addresses to check against queue
- fwd_hit1, fwd_hit2  output  1 each  queue holds a pending write to that register
- fwd_data1, fwd_data2  output  WIDTH each  newest pending value for that register; 0 when no hit
- count  output  $clog2(DEPTH+1)  current occupancy
- empty, full  output  1 each  count==0 / count==DEPTH

## Operation
- Storage: circular buffer of DEPTH {reg, data} entries; head pointer (oldest), tail pointer (next free), occupancy counter. Pointers wrap modulo DEPTH.
- Enqueue: in_valid && in_ready at edge → if in_reg != 31, write entry at tail, tail+1. If in_reg == 31, handshake completes but nothing stored (pointers/count unchanged).
- Drain: RegWrite = !empty && !wb_hold. WriteRegister/WriteData = head entry when !empty, else 0. On edge with RegWrite=1, head+1.
- count next = count + enq_stored − deq. Simultaneous enqueue and drain: both occur, count unchanged. When full, in_ready=0 even if a drain is occurring that cycle (no pass-through).
- Order: writes reach the register file in acceptance order; two queued writes to the same register both drain, newest last.
- Forwarding (combinational from stored entries only, including the head entry being written this cycle): scan all valid entries; hit if any entry reg matches; data from the youngest matching entry (nearest to tail). fwd_reg == 31 never hits. Same-cycle in_* values are not forwarded.
- State machine: none beyond pointers/count; behaviour fully determined by empty/full/hold.

## Timing
- Reset (reset==0 at edge): head=tail=count=0; next cycle RegWrite=0, WriteRegister=0, WriteData=0, empty=1, full=0, in_ready=1, fwd_hit*=0, fwd_data*=0. A reset mid-drain discards all queued entries; no further write is issued. A handshake in the reset cycle is ignored.
- Latency: entry accepted at edge N appears on write port during cycle N+1 (when queue was empty and wb_hold=0); register file captures it at edge N+1 end. Minimum accept-to-commit: 2 edges.
- Throughput: one accept and one drain per cycle sustained.
- wb_hold=1: RegWrite=0, head frozen; write port still shows head entry; enqueue continues until full.
- in_ready, empty, full, count, RegWrite are functions of registered state and wb_hold only; no combinational path from in_valid to in_ready.

## Test plan
- Reset then single write: reset=0 one cycle; in_valid with reg=5, data=0xDEAD_BEEF → next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; following cycle empty=1, RegWrite=0.
- Fill under hold: wb_hold=1, enqueue regs 1,2,3,4 (data 0x10..0x40) → count=4, full=1, in_ready=0, 5th offer not accepted; release hold → writes 1,2,3,4 on four consecutive cycles, count returns to 0.
- Forwarding youngest: hold, enqueue reg7=0xAA then reg7=0xBB; fwd_reg1=7 → fwd_hit1=1, fwd_data1=0xBB; fwd_reg2=8 → fwd_hit2=0, data 0.
- XZR discard: enqueue reg31=0xFFFF → in_ready stays 1, count stays 0, RegWrite never asserted, fwd_reg1=31 → fwd_hit1=0.
- Simultaneous enq/drain with wrap: stream 10 back-to-back writes (reg=i, data=i*3) with hold off → count ≤1 throughout, pointers wrap, write port shows reg i data i*3 in order, one per cycle.
- Reset mid-operation: 3 entries queued under hold, assert reset=0 → next cycle count=0, RegWrite=0, fwd_hit*=0; releasing hold produces no writes.
